// File: rtl/cnn_argmax_classifier_if.sv
// Handshake and data bundle between the FC/softmax stage and the
// argmax classifier: start/scores in, status and result out.
interface cnn_argmax_classifier_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CLASSES    = 10,
    parameter int IDX_WIDTH  = 4
);
    logic                          start;
    logic [CLASSES*DATA_WIDTH-1:0] scores;
    logic                          busy;
    logic                          done;
    logic [IDX_WIDTH-1:0]          class_idx;
    logic [DATA_WIDTH-1:0]         max_score;
    logic                          nan_flag;

    modport master (
        output start, scores,
        input  busy, done, class_idx, max_score, nan_flag
    );

    modport slave (
        input  start, scores,
        output busy, done, class_idx, max_score, nan_flag
    );
endinterface

// File: rtl/cnn_argmax_classifier.sv
// Sequential argmax over a latched vector of IEEE-754 single scores,
// one class per cycle; NaNs are skipped and flagged, ties keep lowest index.
module cnn_argmax_classifier #(
    parameter int DATA_WIDTH = 32,
    parameter int CLASSES    = 10,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    cnn_argmax_classifier_if.slave   bus
);

    localparam logic [DATA_WIDTH-1:0] QNAN = 32'h7FC0_0000;
    localparam logic [IDX_WIDTH-1:0]  LAST = IDX_WIDTH'(CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [CLASSES*DATA_WIDTH-1:0] vec_q, vec_d;
    logic [IDX_WIDTH-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]         best_q, best_d;
    logic [IDX_WIDTH-1:0]          best_idx_q, best_idx_d;
    logic                          best_valid_q, best_valid_d;
    logic                          nan_acc_q, nan_acc_d;
    logic [IDX_WIDTH-1:0]          class_idx_q, class_idx_d;
    logic [DATA_WIDTH-1:0]         max_score_q, max_score_d;
    logic                          nan_flag_q, nan_flag_d;

    logic [DATA_WIDTH-1:0]         elem;
    logic                          elem_nan;

    // +0 and -0 compare equal; negatives order by inverted magnitude
    function automatic logic f_gt(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic res;
        if (a[31] != b[31]) begin
            if (a[30:0] == '0 && b[30:0] == '0) res = 1'b0;
            else                                res = !a[31];
        end else if (!a[31]) begin
            res = a[30:0] > b[30:0];
        end else begin
            res = a[30:0] < b[30:0];
        end
        return res;
    endfunction

    // the latched vector shifts down, so the current element is always at the bottom
    assign elem     = vec_q[DATA_WIDTH-1:0];
    assign elem_nan = (&elem[30:23]) && (|elem[22:0]);

    // next-state, running-best update and result capture
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        best_valid_d = best_valid_q;
        nan_acc_d    = nan_acc_q;
        class_idx_d  = class_idx_q;
        max_score_d  = max_score_q;
        nan_flag_d   = nan_flag_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    vec_d        = bus.scores;
                    cnt_d        = '0;
                    best_d       = '0;
                    best_idx_d   = '0;
                    best_valid_d = 1'b0;
                    nan_acc_d    = 1'b0;
                    state_d      = SCAN;
                end else begin
                    state_d      = IDLE;
                end
            end
            SCAN: begin
                vec_d = vec_q >> DATA_WIDTH;
                cnt_d = cnt_q + 1'b1;
                if (elem_nan) begin
                    nan_acc_d = 1'b1;
                end else if (!best_valid_q || f_gt(elem, best_q)) begin
                    best_d       = elem;
                    best_idx_d   = cnt_q;
                    best_valid_d = 1'b1;
                end
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    class_idx_d = best_idx_d;
                    max_score_d = best_valid_d ? best_d : QNAN;
                    nan_flag_d  = nan_acc_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            best_valid_q <= 1'b0;
            nan_acc_q    <= 1'b0;
            class_idx_q  <= '0;
            max_score_q  <= '0;
            nan_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            best_q       <= best_d;
            best_idx_q   <= best_idx_d;
            best_valid_q <= best_valid_d;
            nan_acc_q    <= nan_acc_d;
            class_idx_q  <= class_idx_d;
            max_score_q  <= max_score_d;
            nan_flag_q   <= nan_flag_d;
        end
    end

    assign bus.busy      = (state_q == SCAN);
    assign bus.done      = (state_q == DONE);
    assign bus.class_idx = class_idx_q;
    assign bus.max_score = max_score_q;
    assign bus.nan_flag  = nan_flag_q;

endmodule

// File: tb/tb_cnn_argmax_classifier.sv
// Bench for cnn_argmax_classifier: directed vectors, random vectors against
// an ordering-key reference model, start-ignore, back-to-back and mid-scan reset.
module tb_cnn_argmax_classifier;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cnn_argmax_classifier_if bus ();

    cnn_argmax_classifier dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // floats map onto signed integers so that ordinary integer order is float order
    function automatic longint fkey(input logic [31:0] f);
        longint m;
        m = longint'(f[30:0]);
        return f[31] ? -m : m;
    endfunction

    function automatic void model(input logic [319:0] v, output logic [3:0] idx,
                                  output logic [31:0] mx, output logic nan);
        bit found;
        logic [31:0] e;
        found = 0;
        idx = 4'd0;
        mx = 32'h7FC0_0000;
        nan = 1'b0;
        for (int i = 0; i < 10; i++) begin
            e = v[i*32 +: 32];
            if (e[30:23] == 8'hFF && e[22:0] != 0) begin
                nan = 1'b1;
            end else if (!found || fkey(e) > fkey(mx)) begin
                found = 1;
                idx = 4'(i);
                mx = e;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // wait for done from within cycle `lat`; returns cycle index it appeared in
    task automatic wait_done(inout int lat);
        while (bus.done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [319:0] v);
        logic [3:0] ei;
        logic [31:0] em;
        logic en;
        model(v, ei, em, en);
        chk({tag, "_idx"}, 32'(bus.class_idx), 32'(ei));
        chk({tag, "_max"}, bus.max_score, em);
        chk({tag, "_nan"}, 32'(bus.nan_flag), 32'(en));
    endtask

    task automatic run(input string tag, input logic [319:0] v);
        int lat;
        logic [3:0] held;
        bus.scores = v;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.scores = ~v;
        lat = 1;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd11);
        chk({tag, "_busy_dn"}, 32'(bus.busy), 32'd0);
        check_result(tag, v);
        held = bus.class_idx;
        step();
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_hold"}, 32'(bus.class_idx), 32'(held));
    endtask

    function automatic logic [31:0] rand_elem(input logic [31:0] prev);
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: return {r[31], 8'hFF, r[22:0] | 23'd1};
            1: return {r[31], 31'h7F80_0000};
            2: return {r[31], 31'd0};
            3: return prev;
            4: return {r[31], 8'h00, r[22:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        logic [319:0] v, v2, v3;
        logic [31:0] p;
        int lat;

        bus.start = 1'b0;
        bus.scores = '0;
        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_idx", 32'(bus.class_idx), 32'd0);
        chk("rst_max", bus.max_score, 32'd0);
        chk("rst_nan", 32'(bus.nan_flag), 32'd0);
        step();
        step();
        rst = 1'b1;

        v = {10{32'h3C23_D70A}};
        v[7*32 +: 32] = 32'h3F66_6666;
        run("c7", v);

        v = {10{32'hC000_0000}};
        v[3*32 +: 32] = 32'hBF00_0000;
        run("neg", v);

        v = '0;
        v[2*32 +: 32] = 32'h3F00_0000;
        v[5*32 +: 32] = 32'h3F00_0000;
        run("tie", v);

        v = '0;
        v[0 +: 32] = 32'h8000_0000;
        run("zero", v);

        v = {10{32'h3F80_0000}};
        v[1*32 +: 32] = 32'h7FC0_0001;
        v[4*32 +: 32] = 32'h7F80_0000;
        run("inf", v);

        v = {10{32'h7FC0_0001}};
        run("allnan", v);

        for (int n = 0; n < 25; n++) begin
            p = $urandom;
            for (int i = 0; i < 10; i++) begin
                p = rand_elem(p);
                v[i*32 +: 32] = p;
            end
            run($sformatf("rnd%0d", n), v);
        end

        v = {10{32'h3F80_0000}};
        v[6*32 +: 32] = 32'h4000_0000;
        v2 = {10{32'h3F00_0000}};
        v2[9*32 +: 32] = 32'h4100_0000;
        bus.scores = v;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        lat = 1;
        step();
        step();
        step();
        lat = 4;
        bus.scores = v2;
        bus.start = 1'b1;
        step();
        lat++;
        bus.start = 1'b0;
        chk("ign_busy", 32'(bus.busy), 32'd1);
        wait_done(lat);
        chk("ign_lat", 32'(lat), 32'd11);
        check_result("ign", v);
        step();
        chk("ign_single", 32'(bus.done), 32'd0);
        step();
        chk("ign_nodone", 32'(bus.done), 32'd0);

        v3 = {10{32'hBF80_0000}};
        v3[8*32 +: 32] = 32'h3E00_0000;
        bus.scores = v2;
        bus.start = 1'b1;
        step();
        bus.scores = v3;
        lat = 1;
        wait_done(lat);
        chk("b2b_lat1", 32'(lat), 32'd11);
        check_result("b2b1", v2);
        step();
        bus.start = 1'b0;
        chk("b2b_noidle", 32'(bus.busy), 32'd1);
        lat = 1;
        wait_done(lat);
        chk("b2b_lat2", 32'(lat), 32'd11);
        check_result("b2b2", v3);
        step();

        v = {10{32'h4040_0000}};
        v[5*32 +: 32] = 32'h7FC0_0000;
        bus.scores = v;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #2;
        rst = 1'b0;
        #1;
        chk("mid_busy", 32'(bus.busy), 32'd0);
        chk("mid_done", 32'(bus.done), 32'd0);
        chk("mid_idx", 32'(bus.class_idx), 32'd0);
        chk("mid_max", bus.max_score, 32'd0);
        chk("mid_nan", 32'(bus.nan_flag), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("mid_nopulse", 32'(bus.done), 32'd0);
        end
        rst = 1'b1;
        v[1*32 +: 32] = 32'h4080_0000;
        run("post", v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
